// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8 (poly 0x07, init 0x00) with frame bit counter
// Optional MSB-first CRC append stage and err flag are enabled by defining CRC8_SERIAL_APPEND_EN.
module crc8_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       si,
  input  logic       en_crc,
  output logic [7:0] crc_out,
  output logic       crc_valid,
  output logic [7:0] bit_cnt,
  output logic       so_crc,
  output logic       so_vld,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, APPEND = 2'd2} state_t;

  state_t     state, state_nx;
  logic [7:0] crc_w, crc_w_nx;
  logic [7:0] cnt_w, cnt_w_nx;
  logic       load;
  logic       start_ok;

`ifdef CRC8_SERIAL_APPEND_EN
  logic [3:0] app_cnt, app_cnt_nx;
  logic [7:0] shreg;
  logic       en_q;
  logic       lock, lock_nx;
  logic       err_nx;
`endif

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = b ^ c[7];
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  always_comb begin
    state_nx = state;
    crc_w_nx = crc_w;
    cnt_w_nx = cnt_w;
    load     = 1'b0;
    start_ok = en_crc;
`ifdef CRC8_SERIAL_APPEND_EN
    // en_crc raised during APPEND belongs to a dropped frame; wait for it to fall
    start_ok   = en_crc & ~lock;
    lock_nx    = en_crc & (lock | (state == APPEND));
    err_nx     = 1'b0;
    app_cnt_nx = 4'd0;
`endif
    case (state)
      IDLE: begin
        crc_w_nx = 8'h00;
        cnt_w_nx = 8'd0;
        if (start_ok) begin
          crc_w_nx = crc_step(8'h00, si);
          cnt_w_nx = 8'd1;
          state_nx = CALC;
        end
      end
      CALC: begin
        if (en_crc) begin
          crc_w_nx = crc_step(crc_w, si);
          cnt_w_nx = (cnt_w == 8'hFF) ? cnt_w : cnt_w + 8'd1;
        end else begin
          load     = 1'b1;
          crc_w_nx = 8'h00;
          cnt_w_nx = 8'd0;
`ifdef CRC8_SERIAL_APPEND_EN
          state_nx = APPEND;
`else
          state_nx = IDLE;
`endif
        end
      end
`ifdef CRC8_SERIAL_APPEND_EN
      APPEND: begin
        // app_cnt 0 is the crc_valid cycle; 1..8 carry the CRC bits
        crc_w_nx = 8'h00;
        cnt_w_nx = 8'd0;
        err_nx   = en_crc & ~en_q;
        if (app_cnt == 4'd8) state_nx = IDLE;
        else                 app_cnt_nx = app_cnt + 4'd1;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      crc_w     <= 8'h00;
      cnt_w     <= 8'd0;
      crc_out   <= 8'h00;
      bit_cnt   <= 8'd0;
      crc_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      crc_w     <= crc_w_nx;
      cnt_w     <= cnt_w_nx;
      crc_valid <= load;
      if (load) begin
        crc_out <= crc_w;
        bit_cnt <= cnt_w;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef CRC8_SERIAL_APPEND_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      app_cnt <= 4'd0;
      shreg   <= 8'h00;
      en_q    <= 1'b0;
      lock    <= 1'b0;
      err     <= 1'b0;
    end else begin
      app_cnt <= app_cnt_nx;
      en_q    <= en_crc;
      lock    <= lock_nx;
      err     <= err_nx;
      if (load)        shreg <= crc_w;
      else if (so_vld) shreg <= {shreg[6:0], 1'b0};
    end
  end

  assign so_vld = (state == APPEND) && (app_cnt != 4'd0);
  assign so_crc = so_vld & shreg[7];
`else
  assign so_vld = 1'b0;
  assign so_crc = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_crc8_serial.sv
// tb/tb_crc8_serial.sv - directed self-checking bench for crc8_serial
// Append-stage checks are active when CRC8_SERIAL_APPEND_EN is defined.
module tb_crc8_serial;

  logic       clk;
  logic       rst;
  logic       si;
  logic       en_crc;
  logic [7:0] crc_out;
  logic       crc_valid;
  logic [7:0] bit_cnt;
  logic       so_crc;
  logic       so_vld;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_err = 0;

  crc8_serial dut (
    .clk       (clk),
    .rst       (rst),
    .si        (si),
    .en_crc    (en_crc),
    .crc_out   (crc_out),
    .crc_valid (crc_valid),
    .bit_cnt   (bit_cnt),
    .so_crc    (so_crc),
    .so_vld    (so_vld),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_crc_out"},   crc_out,   0);
    check({tag, "_bit_cnt"},   bit_cnt,   0);
    check({tag, "_crc_valid"}, crc_valid, 0);
    check({tag, "_so_crc"},    so_crc,    0);
    check({tag, "_so_vld"},    so_vld,    0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_err"},       err,       0);
  endtask

  task automatic finish_frame(input logic [7:0] ec, input logic [7:0] ecnt, input bit inj);
    en_crc = 1'b0;
    si     = 1'b0;
    step();
    check("crc_valid_pulse", crc_valid, 1);
    check("crc_out",         crc_out,   ec);
    check("bit_cnt",         bit_cnt,   ecnt);
`ifdef CRC8_SERIAL_APPEND_EN
    check("lead_so_vld", so_vld, 0);
    check("lead_busy",   busy,   1);
    for (int k = 0; k < 8; k++) begin
      step();
      check("app_so_vld",    so_vld,    1);
      check("app_so_crc",    so_crc,    ec[7-k]);
      check("app_crc_valid", crc_valid, 0);
      check("app_err",       err,       (inj && k == 3));
      if (inj && k == 2) begin en_crc = 1'b1; si = 1'b1; end
      if (inj && k == 4) begin en_crc = 1'b0; si = 1'b0; end
    end
    step();
    check("post_busy",   busy,   0);
    check("post_so_vld", so_vld, 0);
`else
    check("noapp_busy",   busy,   0);
    check("noapp_so_vld", so_vld, 0);
    check("noapp_err",    err,    0);
`endif
    step();
    check("post_crc_valid", crc_valid, 0);
    check("post_crc_hold",  crc_out,   ec);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic [7:0] ec,
                            input logic [7:0] ecnt, input bit inj);
    for (int i = 0; i < nb; i++) begin
      en_crc = 1'b1;
      si     = d[7-i];
      step();
    end
    check("calc_busy",      busy,      1);
    check("calc_crc_valid", crc_valid, 0);
    finish_frame(ec, ecnt, inj);
  endtask

  initial begin
    rst    = 1'b0;
    si     = 1'b0;
    en_crc = 1'b0;
    #2;
    check_idle_outputs("reset");

    // release between edges; frame starts on the very first rising edge
    @(negedge clk);
    rst = 1'b1;
    send_frame(8'h01, 8, 8'h07, 8'd8, 1'b0);

    send_frame(8'hFF, 8, 8'hF3, 8'd8, 1'b0);
    send_frame(8'h80, 8, 8'h89, 8'd8, 1'b0);
    send_frame(8'h80, 1, 8'h07, 8'd1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      en_crc = 1'b1;
      si     = 1'b0;
      step();
    end
    finish_frame(8'h00, 8'd255, 1'b0);

`ifdef CRC8_SERIAL_APPEND_EN
    send_frame(8'hFF, 8, 8'hF3, 8'd8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("drop_crc_valid", crc_valid, 0);
      check("drop_busy",      busy,      0);
    end
`else
    send_frame(8'hFF, 8, 8'hF3, 8'd8, 1'b0);
`endif

    // asynchronous reset after 4 frame bits discards the partial frame
    en_crc = 1'b1;
    si = 1'b1; step();
    si = 1'b0; step();
    si = 1'b1; step();
    si = 1'b1; step();
    check("mid_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    #1;
    en_crc = 1'b0;
    si     = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("after_rst_crc_valid", crc_valid, 0);
      check("after_rst_busy",      busy,      0);
    end
    send_frame(8'h01, 8, 8'h07, 8'd8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
